// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on input and output; holds its result under backpressure.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier for opcode 10 (otherwise it is illegal).
module alu_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             ResetN,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InputA,
   input  logic [WIDTH-1:0] InputB,
   input  logic [3:0]       OP,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Out,
   output logic             Cond,
   output logic             Illegal
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_LSH = 4'd6;
   localparam logic [3:0] OP_RSH = 4'd7;
   localparam logic [3:0] OP_SLT = 4'd8;
   localparam logic [3:0] OP_SEQ = 4'd9;

`ifdef ALU_PIPE_MUL_EN
   localparam logic [1:0] BUSY   = 2'd1;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam int         CNT_W  = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

   logic [2*WIDTH-1:0] mul_a;
   logic [2*WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0]   mul_b;
   logic [CNT_W-1:0]   cnt;
`endif

   logic [1:0]       state;
   logic             accept;
   logic [WIDTH:0]   add_full;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cond;
   logic             alu_ill;
   logic             use_zero;

   // InReady is combinational from OutReady so a held result can be replaced in the same cycle.
   assign InReady  = ResetN && (state == IDLE || (state == DONE && OutReady));
   assign OutValid = (state == DONE);
   assign accept   = InValid && InReady;
   assign add_full = {1'b0, InputA} + {1'b0, InputB};

   // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      alu_res  = '0;
      alu_cond = 1'b0;
      alu_ill  = 1'b0;
      use_zero = 1'b0;
      case (OP)
         OP_ADD: begin
            alu_res  = add_full[WIDTH-1:0];
            alu_cond = add_full[WIDTH];
         end
         OP_SUB: begin
            alu_res  = InputA - InputB;
            alu_cond = (InputA < InputB);
         end
         OP_AND: begin alu_res = InputA & InputB; use_zero = 1'b1; end
         OP_OR:  begin alu_res = InputA | InputB; use_zero = 1'b1; end
         OP_XOR: begin alu_res = InputA ^ InputB; use_zero = 1'b1; end
         OP_NOT: begin alu_res = ~InputA;         use_zero = 1'b1; end
         // Shifting by WIDTH or more already yields zero for logical shifts.
         OP_LSH: begin alu_res = InputA << InputB; use_zero = 1'b1; end
         OP_RSH: begin alu_res = InputA >> InputB; use_zero = 1'b1; end
         OP_SLT: begin
            alu_res  = {{(WIDTH-1){1'b0}}, (InputA < InputB)};
            alu_cond = (InputA < InputB);
         end
         OP_SEQ: begin
            alu_res  = {{(WIDTH-1){1'b0}}, (InputA == InputB)};
            alu_cond = (InputA == InputB);
         end
         default: alu_ill = 1'b1;
      endcase
      if (use_zero) alu_cond = (alu_res == '0);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state   <= IDLE;
         Out     <= '0;
         Cond    <= 1'b0;
         Illegal <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
         cnt     <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_acc <= '0;
`endif
      end else if (accept) begin
`ifdef ALU_PIPE_MUL_EN
         if (OP == OP_MUL) begin
            state   <= BUSY;
            cnt     <= CNT_LOAD;
            mul_a   <= {{WIDTH{1'b0}}, InputA};
            mul_b   <= InputB;
            mul_acc <= '0;
         end else
`endif
         begin
            state   <= DONE;
            Out     <= alu_res;
            Cond    <= alu_cond;
            Illegal <= alu_ill;
         end
      end
`ifdef ALU_PIPE_MUL_EN
      else if (state == BUSY) begin
         // One shift-add step per cycle; the extra cycle at cnt==0 publishes the product.
         if (cnt == '0) begin
            state   <= DONE;
            Out     <= mul_acc[WIDTH-1:0];
            Cond    <= |mul_acc[2*WIDTH-1:WIDTH];
            Illegal <= 1'b0;
         end else begin
            if (mul_b[0]) mul_acc <= mul_acc + mul_a;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt - 1'b1;
         end
      end
`endif
      else if (state == DONE && OutReady) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): literal expectations plus a queue-based scoreboard
// fed by an arithmetic reference model, checked on every output transfer and hold cycle.
module tb_alu_pipe;

   localparam int W = 8;
   localparam int M = 1 << W;

   logic         Clk = 1'b0;
   logic         ResetN = 1'b0;
   logic         InValid = 1'b0;
   logic         OutReady = 1'b1;
   logic [W-1:0] InputA = '0;
   logic [W-1:0] InputB = '0;
   logic [3:0]   OP = '0;
   logic         InReady, OutValid, Cond, Illegal;
   logic [W-1:0] Out;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [W-1:0] out;
      logic         cond;
      logic         ill;
   } res_t;

   res_t expq[$];
   res_t exp_r;
   res_t pin_r;

   logic         held_v = 1'b0;
   logic [W-1:0] held_out;
   logic         held_c, held_i;

   logic [3:0]   sw_op  [7] = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13};
   logic [W-1:0] sw_a   [7] = '{8'h03, 8'hF0, 8'h99, 8'h99, 8'h05, 8'h07, 8'h00};
   logic [W-1:0] sw_b   [7] = '{8'h05, 8'h00, 8'h09, 8'h03, 8'h03, 8'h07, 8'h00};
   logic [W-1:0] sw_out [7] = '{8'hFE, 8'h0F, 8'h00, 8'h13, 8'h00, 8'h01, 8'h00};
   logic         sw_c   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
   logic         sw_i   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   logic [W-1:0] b2b_a   [4] = '{8'h01, 8'h10, 8'hF0, 8'h80};
   logic [W-1:0] b2b_b   [4] = '{8'h02, 8'h20, 8'h10, 8'h80};
   logic [W-1:0] b2b_out [4] = '{8'h03, 8'h30, 8'h00, 8'h00};
   logic         b2b_c   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   alu_pipe #(.WIDTH(W)) dut (
      .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
      .InputA(InputA), .InputB(InputB), .OP(OP), .OutValid(OutValid),
      .OutReady(OutReady), .Out(Out), .Cond(Cond), .Illegal(Illegal)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model: results from plain integer arithmetic on the opcode table.
   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      int   ia, ib, full;
      ia = int'(a);
      ib = int'(b);
      r.out = '0;
      r.cond = 1'b0;
      r.ill = 1'b0;
      case (op)
         4'd0: begin full = ia + ib; r.out = W'(full % M); r.cond = (full >= M); end
         4'd1: begin full = ia - ib; r.out = W'((full + M) % M); r.cond = (ia < ib); end
         4'd2: begin r.out = a & b; r.cond = (r.out == 0); end
         4'd3: begin r.out = a | b; r.cond = (r.out == 0); end
         4'd4: begin r.out = a ^ b; r.cond = (r.out == 0); end
         4'd5: begin r.out = ~a;    r.cond = (r.out == 0); end
         4'd6: begin r.out = (ib >= W) ? '0 : W'((ia << ib) % M); r.cond = (r.out == 0); end
         4'd7: begin r.out = (ib >= W) ? '0 : W'(ia >> ib);       r.cond = (r.out == 0); end
         4'd8: begin r.out = (ia < ib) ? 1 : 0;  r.cond = (ia < ib); end
         4'd9: begin r.out = (ia == ib) ? 1 : 0; r.cond = (ia == ib); end
`ifdef ALU_PIPE_MUL_EN
         4'd10: begin full = ia * ib; r.out = W'(full % M); r.cond = (full >= M); end
`endif
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   // Scoreboard: sampled mid-cycle, between driver updates and the next active edge.
   always @(negedge Clk) begin
      if (!ResetN) begin
         expq.delete();
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_valid", OutValid, 1);
            check("hold_out", Out, held_out);
            check("hold_cond", Cond, held_c);
            check("hold_illegal", Illegal, held_i);
         end
         held_v   = OutValid && !OutReady;
         held_out = Out;
         held_c   = Cond;
         held_i   = Illegal;
         if (OutValid && OutReady) begin
            if (expq.size() == 0) begin
               check("result_without_input", expq.size(), 1);
            end else begin
               exp_r = expq.pop_front();
               check("sb_out", Out, exp_r.out);
               check("sb_cond", Cond, exp_r.cond);
               check("sb_illegal", Illegal, exp_r.ill);
            end
         end
         if (InValid && InReady) expq.push_back(model(OP, InputA, InputB));
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Presents one operation and returns just after the edge that accepted it.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      InValid = 1'b1;
      OP = op;
      InputA = a;
      InputB = b;
      while (!InReady && n < 50) begin
         tick();
         n++;
      end
      check("send_accept", InReady, 1);
      tick();
      InValid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;

      pin_r = model(4'd0, 8'hFF, 8'h01);
      check("model_pin_add_out", pin_r.out, 8'h00);
      check("model_pin_add_cond", pin_r.cond, 1);
      pin_r = model(4'd6, 8'h99, 8'h09);
      check("model_pin_lsh_out", pin_r.out, 8'h00);
      check("model_pin_lsh_cond", pin_r.cond, 1);

      // Reset and first ADD
      repeat (2) tick();
      check("rst_outvalid", OutValid, 0);
      check("rst_out", Out, 0);
      check("rst_cond", Cond, 0);
      check("rst_illegal", Illegal, 0);
      check("rst_inready", InReady, 0);
      ResetN = 1'b1;
      #1;
      check("post_rst_inready", InReady, 1);
      check("post_rst_outvalid", OutValid, 0);
      send(4'd0, 8'hFF, 8'h01);
      check("add_valid", OutValid, 1);
      check("add_out", Out, 8'h00);
      check("add_cond", Cond, 1);
      check("add_illegal", Illegal, 0);

      // Back-to-back sweep of single-cycle ops
      for (int i = 0; i < 7; i++) begin
         send(sw_op[i], sw_a[i], sw_b[i]);
         check("sweep_valid", OutValid, 1);
         check("sweep_out", Out, sw_out[i]);
         check("sweep_cond", Cond, sw_c[i]);
         check("sweep_illegal", Illegal, sw_i[i]);
      end
      tick();
      check("idle_after_drain", OutValid, 0);

`ifdef ALU_PIPE_MUL_EN
      send(4'd10, 8'd13, 8'd11);
      for (int i = 0; i < 9; i++) begin
         check("mul_busy_outvalid", OutValid, 0);
         check("mul_busy_inready", InReady, 0);
         tick();
      end
      check("mul_valid", OutValid, 1);
      check("mul_out", Out, 8'h8F);
      check("mul_cond", Cond, 0);
      send(4'd10, 8'h20, 8'h10);
      n = 0;
      while (!OutValid && n < 20) begin
         tick();
         n++;
      end
      check("mul2_latency", n, 9);
      check("mul2_out", Out, 8'h00);
      check("mul2_cond", Cond, 1);
      tick();
`else
      send(4'd10, 8'd3, 8'd4);
      check("op10_valid", OutValid, 1);
      check("op10_out", Out, 8'h00);
      check("op10_cond", Cond, 0);
      check("op10_illegal", Illegal, 1);
      tick();
`endif

      // Backpressure then back-to-back throughput
      OutReady = 1'b0;
      send(4'd2, 8'hF0, 8'hCC);
      check("and_out", Out, 8'hC0);
      check("and_cond", Cond, 0);
      InValid = 1'b1;
      OP = 4'd0;
      InputA = b2b_a[0];
      InputB = b2b_b[0];
      for (int i = 0; i < 3; i++) begin
         check("bp_inready", InReady, 0);
         tick();
         check("bp_valid", OutValid, 1);
         check("bp_out", Out, 8'hC0);
      end
      OutReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         InValid = 1'b1;
         OP = 4'd0;
         InputA = b2b_a[i];
         InputB = b2b_b[i];
         tick();
         check("b2b_valid", OutValid, 1);
         check("b2b_out", Out, b2b_out[i]);
         check("b2b_cond", Cond, b2b_c[i]);
      end
      InValid = 1'b0;
      tick();
      check("b2b_drained", OutValid, 0);

      // Reset during an operation in flight
`ifdef ALU_PIPE_MUL_EN
      send(4'd10, 8'd13, 8'd11);
      repeat (3) tick();
`else
      OutReady = 1'b0;
      send(4'd0, 8'h11, 8'h22);
      tick();
`endif
      ResetN = 1'b0;
      tick();
      check("midrst_outvalid", OutValid, 0);
      check("midrst_out", Out, 0);
      check("midrst_cond", Cond, 0);
      check("midrst_inready", InReady, 0);
      ResetN = 1'b1;
      OutReady = 1'b1;
      #1;
      check("midrst_inready_after", InReady, 1);
      check("midrst_outvalid_after", OutValid, 0);
      send(4'd0, 8'h02, 8'h02);
      check("post_midrst_add", Out, 8'h04);
      check("post_midrst_valid", OutValid, 1);

      repeat (3) tick();
      check("queue_drained", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
